knight_sprite_animator: RTL
===========================

# knight_sprite_animator

Consumes the player block's status, facing and position outputs and turns them into a per-pixel sprite ROM address plus an on-sprite flag for the colour mapper. Sequences animation frames per player status: idle, walk, jump and fall loop; attack is a one-shot; death holds on its last frame. Sits between the player block and the Knight sprite ROM. Runs on the pixel clock and samples `frame_clk` as a data strobe.

## Interface
- `SPR_W`, 32: sprite cell width in pixels (power of 2).
- `SPR_H`, 64: sprite cell height in pixels (power of 2).
- `FRAME_DIV`, 6: frame ticks per animation step (1..15).
- `N_IDLE`, `N_WALK`, `N_JUMP`, `N_FALL`, `N_ATK`, `N_DEAD`; defaults 4, 6, 2, 2, 4, 6: frames per animation (1..8).
- `ADDR_W`, 16: ROM address width.

Ports:
- `Clk` in 1: pixel clock. One clock domain only.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vsync-rate strobe, treated as data.
- `Player_Status` in 4: 0 idle, 1 walk, 2 jump up, 3 fall, 4 attack, 5 dead.
- `Inverse` in 1: 1 means facing left (mirror horizontally).
- `PlayerX`, `PlayerY` in 10: sprite centre.
- `DrawX`, `DrawY` in 10: current pixel.
- `sprite_on` out 1: the pixel from the previous cycle lies inside the sprite box.
- `sprite_addr` out ADDR_W: ROM address for that pixel.
- `anim_frame` out 3: current frame index within the active animation.
- `attack_active` out 1: attack hitbox window.
- `death_done` out 1: death animation has finished.

## Operation
- Frame tick:
  - `frame_clk` passes through a 2-flop synchroniser.
  - A rising edge on the synchronised signal produces `tick` for exactly 1 cycle.
- Effective animation `eff`:
  - ATK while `atk_play` = 1.
  - Otherwise `Player_Status`.
  - Values 6..15 map to idle.
- Attack one-shot:
  - `atk_play` sets when `Player_Status` = 4 and `atk_play` = 0 and the status registered last cycle was not 4 (edge trigger).
  - Retriggers while playing are ignored.
  - `atk_play` clears when the last attack frame completes its step.
  - Holding status 4 after the attack ends does not replay it; a new 0→4 edge is required.
- Animation change: when `eff` differs from the registered `cur_anim`:
  - `cur_anim` ← `eff`, frame ← 0, div ← 0, in the same cycle.
  - This takes priority over a simultaneous tick.
- Stepping, on `tick` when there is no change:
  - If div = FRAME_DIV-1, then div ← 0 and the frame advances; otherwise div ← div+1.
  - Idle, walk, jump and fall wrap from N-1 to 0.
  - Attack at N_ATK-1 returns frame to 0 and clears `atk_play`.
  - Dead saturates at N_DEAD-1 and sets `death_done`.
- `death_done` clears only on reset or when `cur_anim` leaves dead.
- `attack_active` = 1 iff `cur_anim` = ATK and frame ∈ {1, 2}. It is registered with the frame counter, so it has no extra latency.
- Base frame per animation is cumulative in the order idle, walk, jump, fall, attack, dead. Defaults: 0, 4, 10, 12, 14, 18.
- Pixel path (11-bit signed arithmetic):
  - L = PlayerX − SPR_W/2, T = PlayerY − SPR_H/2.
  - inside = DrawX ≥ L && DrawX < L+SPR_W && DrawY ≥ T && DrawY < T+SPR_H.
  - Negative L or T must not wrap. If PlayerX = 10, then DrawX 0..25 is inside.
  - col = DrawX − L; if `Inverse` = 1 then col ← SPR_W−1−col.
  - row = DrawY − T.
  - addr = (base + frame)·SPR_W·SPR_H + row·SPR_W + col, truncated to ADDR_W bits.
  - When outside, `sprite_addr` = 0.

## Timing
- Reset (async assert, sync release): all outputs 0; `cur_anim` = idle, frame 0, div 0, `atk_play` 0, synchroniser flops 0.
- Latency from a `frame_clk` rise to `tick` is 2–3 Clk cycles.
- Pixel path latency is exactly 1 cycle: `sprite_on` and `sprite_addr` at cycle n+1 reflect `DrawX`/`DrawY`/`PlayerX`/`PlayerY`/`Inverse` at cycle n.
- The frame used for a pixel is the frame value registered in cycle n.
- Status change to `anim_frame` = 0 takes 1 cycle.
- Reset asserted mid-attack or mid-death returns the block to idle immediately and clears `death_done`.

## Test plan
- Reset, status 0, 48 frame_clk pulses with FRAME_DIV = 6: `anim_frame` steps every 6 ticks through 0,1,2,3,0,1,2,3; `attack_active` stays 0.
- Status 1, then status 2 asserted on the same cycle as a step tick: frame = 0 and div = 0 one cycle later; the jump frames then advance 0,1,0 every 6 ticks.
- Status 4 for 1 cycle, then 0: attack plays frames 0..3 (24 ticks); `attack_active` is high during frames 1–2 only; then the block returns to idle frame 0. Status held at 4 for 100 ticks yields a single attack.
- Status 5 for 60 ticks: frames 0..5, then hold at 5; `death_done` = 1 from the step into frame 5. Asserting Reset_n = 0 mid-hold clears all outputs asynchronously.
- PlayerX = 320, PlayerY = 377, idle frame 0, Inverse = 0:
  - DrawX = 304, DrawY = 345 gives `sprite_on` = 1 and addr 0 next cycle.
  - DrawX = 335, DrawY = 345 gives addr 31.
  - DrawX = 336 gives `sprite_on` = 0.
  - With Inverse = 1, DrawX = 304 gives addr 31.
- PlayerX = 10, DrawX = 0, DrawY inside: `sprite_on` = 1 and col = 6, so addr = row·32 + 6. PlayerX = 10, DrawX = 1020: `sprite_on` = 0.

Source files
------------

// File: rtl/knight_sprite_animator.sv
// knight_sprite_animator: sequences Knight animation frames from player status
// and maps the current pixel into a sprite ROM address (one cycle latency).
module knight_sprite_animator #(
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 64,
  parameter int FRAME_DIV = 6,
  parameter int N_IDLE    = 4,
  parameter int N_WALK    = 6,
  parameter int N_JUMP    = 2,
  parameter int N_FALL    = 2,
  parameter int N_ATK     = 4,
  parameter int N_DEAD    = 6,
  parameter int ADDR_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [3:0]        Player_Status,
  input  logic              Inverse,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              sprite_on,
  output logic [ADDR_W-1:0] sprite_addr,
  output logic [2:0]        anim_frame,
  output logic              attack_active,
  output logic              death_done
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [2:0] {
    A_IDLE = 3'd0, A_WALK = 3'd1, A_JUMP = 3'd2,
    A_FALL = 3'd3, A_ATK  = 3'd4, A_DEAD = 3'd5
  } anim_e;

  function automatic int nfr_of(anim_e a);
    case (a)
      A_WALK:  return N_WALK;
      A_JUMP:  return N_JUMP;
      A_FALL:  return N_FALL;
      A_ATK:   return N_ATK;
      A_DEAD:  return N_DEAD;
      default: return N_IDLE;
    endcase
  endfunction

  // First ROM frame of each animation; frames are packed back to back.
  function automatic int base_of(anim_e a);
    case (a)
      A_WALK:  return N_IDLE;
      A_JUMP:  return N_IDLE + N_WALK;
      A_FALL:  return N_IDLE + N_WALK + N_JUMP;
      A_ATK:   return N_IDLE + N_WALK + N_JUMP + N_FALL;
      A_DEAD:  return N_IDLE + N_WALK + N_JUMP + N_FALL + N_ATK;
      default: return 0;
    endcase
  endfunction

  logic [1:0]        sync_q;
  logic              sync_prev_q;
  logic              tick;
  logic [3:0]        stat_prev_q;
  anim_e             cur_q, cur_d, eff;
  logic [2:0]        frame_q, frame_d;
  logic [3:0]        div_q, div_d;
  logic              atk_play_q, atk_play_d, atk_set;
  logic              done_q, done_d;
  logic              atk_act_q, atk_act_d;
  logic              sprite_on_q, sprite_on_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [11:0]       dx, dy;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [31:0]       addr_full;

  assign tick = sync_q[1] & ~sync_prev_q;

  // Pick the animation to show and advance frame/divider on ticks.
  always_comb begin
    atk_set = (Player_Status == 4'd4) && !atk_play_q && (stat_prev_q != 4'd4);
    // A held status 4 that did not trigger an attack shows idle.
    if (atk_play_q || atk_set) eff = A_ATK;
    else begin
      case (Player_Status)
        4'd1:    eff = A_WALK;
        4'd2:    eff = A_JUMP;
        4'd3:    eff = A_FALL;
        4'd5:    eff = A_DEAD;
        default: eff = A_IDLE;
      endcase
    end
    cur_d      = cur_q;
    frame_d    = frame_q;
    div_d      = div_q;
    atk_play_d = atk_play_q | atk_set;
    done_d     = done_q;
    if (eff != cur_q) begin
      cur_d   = eff;
      frame_d = '0;
      div_d   = '0;
      done_d  = 1'b0;
    end else if (tick) begin
      if (div_q == 4'(FRAME_DIV - 1)) begin
        div_d = '0;
        case (cur_q)
          A_ATK: begin
            if (frame_q == 3'(N_ATK - 1)) begin
              frame_d    = '0;
              atk_play_d = 1'b0;
            end else frame_d = frame_q + 3'd1;
          end
          A_DEAD: begin
            if (frame_q != 3'(N_DEAD - 1)) frame_d = frame_q + 3'd1;
            if (frame_d == 3'(N_DEAD - 1)) done_d = 1'b1;
          end
          default: begin
            if (int'(frame_q) >= nfr_of(cur_q) - 1) frame_d = '0;
            else frame_d = frame_q + 3'd1;
          end
        endcase
      end else begin
        div_d = div_q + 4'd1;
      end
    end
    atk_act_d = (cur_d == A_ATK) && (frame_d == 3'd1 || frame_d == 3'd2);
  end

  // Pixel-to-ROM mapping; offsets carry enough bits that no screen position wraps.
  always_comb begin
    dx = {2'b00, DrawX} - {2'b00, PlayerX} + 12'(SPR_W / 2);
    dy = {2'b00, DrawY} - {2'b00, PlayerY} + 12'(SPR_H / 2);
    sprite_on_d = !dx[11] && (dx < 12'(SPR_W)) && !dy[11] && (dy < 12'(SPR_H));
    // Mirroring within a power-of-2 cell is a bitwise inversion of the column.
    col = dx[CW-1:0] ^ {CW{Inverse}};
    row = dy[RW-1:0];
    addr_full = (32'(base_of(cur_q)) + 32'(frame_q)) * 32'(SPR_W * SPR_H)
              + 32'(row) * 32'(SPR_W) + 32'(col);
    addr_d = sprite_on_d ? addr_full[ADDR_W-1:0] : '0;
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      stat_prev_q <= '0;
      cur_q       <= A_IDLE;
      frame_q     <= '0;
      div_q       <= '0;
      atk_play_q  <= 1'b0;
      done_q      <= 1'b0;
      atk_act_q   <= 1'b0;
      sprite_on_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      sync_q      <= {sync_q[0], frame_clk};
      sync_prev_q <= sync_q[1];
      stat_prev_q <= Player_Status;
      cur_q       <= cur_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      atk_play_q  <= atk_play_d;
      done_q      <= done_d;
      atk_act_q   <= atk_act_d;
      sprite_on_q <= sprite_on_d;
      addr_q      <= addr_d;
    end
  end

  assign sprite_on     = sprite_on_q;
  assign sprite_addr   = addr_q;
  assign anim_frame    = frame_q;
  assign attack_active = atk_act_q;
  assign death_done    = done_q;

endmodule
